// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer between MEM and CP0: picks the highest-priority
// event and drives a one-cycle CP0 entry followed by a fixed-length pipeline flush.
//
// state | meaning
// IDLE  | watching the MEM stage for exceptions and interrupts
// ENTRY | one cycle presenting the latched event to CP0, flush starts
// FLUSH | flush held until the down-counter reaches zero
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic        mem_syscall_i,
  input  logic        mem_ri_i,
  input  logic        mem_trap_i,
  input  logic        mem_ov_i,
  input  logic        mem_eret_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, ENTRY, FLUSH} state_t;

  // ENTRY already accounts for one flush cycle and the counter is zero-terminated.
  localparam logic [3:0] CNT_LOAD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [31:0] code_q, pc_q, target_q;
  logic        ds_q;

  logic [31:0] status_eff, cause_eff, epc_eff;
  logic        int_pend;
  logic [31:0] det_code;

  always_comb begin
    status_eff = cp0_status_i;
    cause_eff  = cp0_cause_i;
    epc_eff    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      if (wb_cp0_waddr_i == 5'd12) status_eff = wb_cp0_wdata_i;
      if (wb_cp0_waddr_i == 5'd13) cause_eff[9:8] = wb_cp0_wdata_i[9:8];
      if (wb_cp0_waddr_i == 5'd14) epc_eff = wb_cp0_wdata_i;
    end
  end

  assign int_pend = status_eff[0] & ~status_eff[1] & (|(cause_eff[15:8] & status_eff[15:8]));

  always_comb begin
    det_code = 32'h0;
    if (mem_valid_i) begin
      if      (int_pend)      det_code = 32'h1;
      else if (mem_syscall_i) det_code = 32'h8;
      else if (mem_ri_i)      det_code = 32'ha;
      else if (mem_trap_i)    det_code = 32'hd;
      else if (mem_ov_i)      det_code = 32'hc;
      else if (mem_eret_i)    det_code = 32'he;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      code_q   <= 32'h0;
      pc_q     <= 32'h0;
      ds_q     <= 1'b0;
      target_q <= 32'h0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (det_code != 32'h0) begin
            code_q   <= det_code;
            pc_q     <= mem_pc_i;
            ds_q     <= mem_in_delayslot_i;
            target_q <= (det_code == 32'he) ? epc_eff : EXC_VECTOR;
          end
        end
        ENTRY: cnt_q <= CNT_LOAD;
        FLUSH: if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        default: cnt_q <= 4'd0;
      endcase
    end
  end

  always_comb begin
    state_d             = state_q;
    excepttype_o        = 32'h0;
    current_inst_addr_o = 32'h0;
    is_in_delayslot_o   = 1'b0;
    flush_o             = 1'b0;
    new_pc_o            = 32'h0;
    busy_o              = 1'b0;
    case (state_q)
      IDLE: begin
        if (det_code != 32'h0) state_d = ENTRY;
      end
      ENTRY: begin
        excepttype_o        = code_q;
        current_inst_addr_o = pc_q;
        is_in_delayslot_o   = ds_q;
        flush_o             = 1'b1;
        new_pc_o            = target_q;
        busy_o              = 1'b1;
        state_d             = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
      end
      FLUSH: begin
        flush_o  = 1'b1;
        new_pc_o = target_q;
        busy_o   = 1'b1;
        if (cnt_q == 4'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: three instances (FLUSH_CYCLES 2, 4, 1) on shared stimulus.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i, mem_in_delayslot_i;
  logic [31:0] mem_pc_i;
  logic        mem_syscall_i, mem_ri_i, mem_trap_i, mem_ov_i, mem_eret_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_wdata_i;

  logic [31:0] exc2, addr2, npc2, exc4, addr4, npc4, exc1, addr1, npc1;
  logic        ds2, fl2, bz2, ds4, fl4, bz4, ds1, fl1, bz1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exc_ctrl #(.EXC_VECTOR(32'h20), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i),
    .mem_in_delayslot_i(mem_in_delayslot_i), .mem_syscall_i(mem_syscall_i),
    .mem_ri_i(mem_ri_i), .mem_trap_i(mem_trap_i), .mem_ov_i(mem_ov_i),
    .mem_eret_i(mem_eret_i), .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i),
    .cp0_epc_i(cp0_epc_i), .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i),
    .wb_cp0_wdata_i(wb_cp0_wdata_i), .excepttype_o(exc2), .current_inst_addr_o(addr2),
    .is_in_delayslot_o(ds2), .flush_o(fl2), .new_pc_o(npc2), .busy_o(bz2));

  exc_ctrl #(.EXC_VECTOR(32'h20), .FLUSH_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i),
    .mem_in_delayslot_i(mem_in_delayslot_i), .mem_syscall_i(mem_syscall_i),
    .mem_ri_i(mem_ri_i), .mem_trap_i(mem_trap_i), .mem_ov_i(mem_ov_i),
    .mem_eret_i(mem_eret_i), .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i),
    .cp0_epc_i(cp0_epc_i), .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i),
    .wb_cp0_wdata_i(wb_cp0_wdata_i), .excepttype_o(exc4), .current_inst_addr_o(addr4),
    .is_in_delayslot_o(ds4), .flush_o(fl4), .new_pc_o(npc4), .busy_o(bz4));

  exc_ctrl #(.EXC_VECTOR(32'h20), .FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i),
    .mem_in_delayslot_i(mem_in_delayslot_i), .mem_syscall_i(mem_syscall_i),
    .mem_ri_i(mem_ri_i), .mem_trap_i(mem_trap_i), .mem_ov_i(mem_ov_i),
    .mem_eret_i(mem_eret_i), .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i),
    .cp0_epc_i(cp0_epc_i), .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i),
    .wb_cp0_wdata_i(wb_cp0_wdata_i), .excepttype_o(exc1), .current_inst_addr_o(addr1),
    .is_in_delayslot_o(ds1), .flush_o(fl1), .new_pc_o(npc1), .busy_o(bz1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    mem_valid_i = 0; mem_pc_i = 0; mem_in_delayslot_i = 0;
    mem_syscall_i = 0; mem_ri_i = 0; mem_trap_i = 0; mem_ov_i = 0; mem_eret_i = 0;
    cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0;
    wb_cp0_we_i = 0; wb_cp0_waddr_i = 0; wb_cp0_wdata_i = 0;
  endtask

  task automatic do_reset();
    clr();
    #2 rst = 0;
    #2 rst = 1;
    tick();
  endtask

  initial begin
    rst = 0;
    clr();
    #1;
    chk("rst_exc", exc2, 32'h0);
    chk("rst_addr", addr2, 32'h0);
    chk("rst_flags", {28'h0, ds2, fl2, bz2, 1'b0}, 32'h0);
    chk("rst_npc", npc2, 32'h0);
    tick(); tick();
    rst = 1;
    tick();

    // priority: syscall beats ov and eret
    mem_valid_i = 1; mem_pc_i = 32'h40; mem_in_delayslot_i = 1;
    mem_syscall_i = 1; mem_ov_i = 1; mem_eret_i = 1;
    tick();
    clr();
    chk("pri_exc", exc2, 32'h8);
    chk("pri_addr", addr2, 32'h40);
    chk("pri_ds", {31'h0, ds2}, 32'h1);
    chk("pri_npc", npc2, 32'h20);
    chk("pri_fl1", {31'h0, fl2}, 32'h1);
    tick();
    chk("pri_exc2", exc2, 32'h0);
    chk("pri_addr2", addr2, 32'h0);
    chk("pri_fl2", {31'h0, fl2}, 32'h1);
    chk("pri_npc2", npc2, 32'h20);
    tick();
    chk("pri_fl3", {31'h0, fl2}, 32'h0);
    chk("pri_busy3", {31'h0, bz2}, 32'h0);
    chk("pri_npc3", npc2, 32'h0);

    // interrupt gating
    mem_valid_i = 1; cp0_status_i = 32'h401; cp0_cause_i = 32'h400;
    tick();
    clr();
    chk("int_take", exc2, 32'h1);
    chk("int_npc", npc2, 32'h20);
    tick(); tick();
    mem_valid_i = 1; cp0_status_i = 32'h403; cp0_cause_i = 32'h400;
    tick();
    chk("int_exl", exc2, 32'h0);
    chk("int_exl_busy", {31'h0, bz2}, 32'h0);
    cp0_status_i = 32'h400;
    tick();
    chk("int_ie0", exc2, 32'h0);
    cp0_status_i = 32'h401; mem_valid_i = 0;
    tick();
    chk("int_novalid", exc2, 32'h0);
    chk("int_novalid_busy", {31'h0, bz2}, 32'h0);
    clr();

    // forwarding: EPC for eret, Status for interrupt, only Cause[9:8]
    mem_valid_i = 1; mem_pc_i = 32'h60; mem_eret_i = 1; cp0_epc_i = 32'h500;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd14; wb_cp0_wdata_i = 32'h800;
    tick();
    clr();
    chk("fwd_epc_exc", exc2, 32'he);
    chk("fwd_epc_npc", npc2, 32'h800);
    tick(); tick();
    mem_valid_i = 1; cp0_cause_i = 32'h400;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd12; wb_cp0_wdata_i = 32'h401;
    tick();
    clr();
    chk("fwd_status", exc2, 32'h1);
    tick(); tick();
    mem_valid_i = 1; cp0_status_i = 32'h101;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd13; wb_cp0_wdata_i = 32'h100;
    tick();
    clr();
    chk("fwd_cause_sw", exc2, 32'h1);
    tick(); tick();
    mem_valid_i = 1; cp0_status_i = 32'h401;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd13; wb_cp0_wdata_i = 32'h400;
    tick();
    clr();
    chk("fwd_cause_hw", exc2, 32'h0);

    // reset mid-flush
    mem_valid_i = 1; mem_pc_i = 32'h100; mem_syscall_i = 1;
    tick();
    clr();
    chk("rmf_entry", exc2, 32'h8);
    tick();
    chk("rmf_flush", {31'h0, fl2}, 32'h1);
    #2 rst = 0;
    #1;
    chk("rmf_fl", {31'h0, fl2}, 32'h0);
    chk("rmf_busy", {31'h0, bz2}, 32'h0);
    chk("rmf_npc", npc2, 32'h0);
    #2 rst = 1;
    tick();
    chk("rmf_idle", {30'h0, fl2, bz2}, 32'h0);
    mem_valid_i = 1; mem_pc_i = 32'h200; mem_ov_i = 1;
    tick();
    clr();
    chk("rmf_ov", exc2, 32'hc);
    chk("rmf_ov_addr", addr2, 32'h200);

    // busy window with FLUSH_CYCLES = 4
    do_reset();
    mem_valid_i = 1; mem_pc_i = 32'h300; mem_ri_i = 1;
    tick();
    chk("bw_ri", exc4, 32'ha);
    chk("bw_busy1", {31'h0, bz4}, 32'h1);
    mem_ri_i = 0; mem_trap_i = 1; mem_pc_i = 32'h304;
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk($sformatf("bw_exc_k%0d", i), exc4, 32'h0);
      chk($sformatf("bw_busy_k%0d", i), {30'h0, bz4, fl4}, 32'h3);
    end
    tick();
    chk("bw_idle_k5", {30'h0, bz4, fl4}, 32'h0);
    tick();
    clr();
    chk("bw_trap_k6", exc4, 32'hd);
    chk("bw_trap_addr", addr4, 32'h304);

    // FLUSH_CYCLES = 1, ov held every cycle
    do_reset();
    mem_valid_i = 1; mem_pc_i = 32'h400; mem_ov_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("f1_entry%0d", i), {exc1[7:0], 22'h0, fl1, bz1}, {8'hc, 24'h3});
      tick();
      chk($sformatf("f1_idle%0d", i), {exc1[7:0], 22'h0, fl1, bz1}, 32'h0);
    end
    clr();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
